// File: rtl/dmem_store_buffer_pkg.sv
// Shared types for the data-memory store buffer.
//   sb_entry_t : one posted store {valid, word index, data}
//   sb_state_t : buffer mode, normal run or forced drain (flush)
package dmem_store_buffer_pkg;

  localparam int unsigned ADDR_BITS_DEFAULT = 10;
  localparam int unsigned SB_DEPTH_DEFAULT  = 4;
  localparam int unsigned INDEX_W           = ADDR_BITS_DEFAULT - 2;

  typedef struct packed {
    logic               valid;
    logic [INDEX_W-1:0] index;
    logic [31:0]        data;
  } sb_entry_t;

  typedef enum logic {
    SB_RUN   = 1'b0,
    SB_FLUSH = 1'b1
  } sb_state_t;

endpackage

// File: rtl/dmem_ram_array.sv
// Single-port word RAM: asynchronous read, synchronous write, no reset.
//   clock : write clock
//   we    : write enable
//   addr  : word index shared by read and write
//   wd    : write data
//   rd    : read data at addr (combinational)
module dmem_ram_array
  import dmem_store_buffer_pkg::*;
#(
  parameter int unsigned IDX_W = INDEX_W
) (
  input  logic             clock,
  input  logic             we,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wd,
  output logic [31:0]      rd
);

  localparam int unsigned WORDS = 1 << IDX_W;

  logic [31:0] mem [WORDS];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wd;
  end

  assign rd = mem[addr];

endmodule

// File: rtl/dmem_store_buffer.sv
// Data-memory responder with a posted-store FIFO in front of a single-port RAM.
// Stores are buffered and drained when the port is free; loads forward the
// youngest buffered value for their word, otherwise read the RAM.
//   clock, reset         : rising-edge clock, synchronous active-high reset
//   dmem_we / dmem_re    : store / load request
//   dmem_addr, dmem_wd   : byte address and store data
//   dmem_rd              : load data, same cycle as dmem_re
//   dmem_stall           : request not accepted this cycle
//   flush_req/flush_done : drain-all request and completion pulse
//   sb_count / sb_empty  : buffer occupancy
module dmem_store_buffer
  import dmem_store_buffer_pkg::*;
#(
  parameter int unsigned ADDR_BITS = ADDR_BITS_DEFAULT,
  parameter int unsigned SB_DEPTH  = SB_DEPTH_DEFAULT
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        dmem_we,
  input  logic                        dmem_re,
  input  logic [31:0]                 dmem_addr,
  input  logic [31:0]                 dmem_wd,
  output logic [31:0]                 dmem_rd,
  output logic                        dmem_stall,
  input  logic                        flush_req,
  output logic                        flush_done,
  output logic [$clog2(SB_DEPTH):0]   sb_count,
  output logic                        sb_empty
);

  localparam int unsigned PTR_W = $clog2(SB_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  sb_entry_t          entries [SB_DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;
  sb_state_t          state;
  sb_state_t          state_next;
  logic               done_q;
  logic               done_next;

  logic [INDEX_W-1:0] req_index;
  logic [INDEX_W-1:0] ram_addr;
  logic [31:0]        ram_rd;
  logic               full;
  logic               empty;
  logic               drain;
  logic               enq;
  logic               fwd_hit;
  logic [31:0]        fwd_data;
  logic               unused_addr_bits;

  // Word index; byte offset and bits above the decoded range alias.
  assign req_index        = INDEX_W'(dmem_addr[ADDR_BITS-1:2]);
  assign unused_addr_bits = ^{dmem_addr[1:0], dmem_addr[31:ADDR_BITS]};

  assign full  = (count == CNT_W'(SB_DEPTH));
  assign empty = (count == '0);
  // The RAM port is free for the head entry unless a RUN-mode load owns it.
  assign drain = !empty && (state == SB_FLUSH || !dmem_re);
  // A full buffer still accepts when the head leaves on the same edge.
  assign enq   = (state == SB_RUN) && dmem_we && (!full || drain);

  // Youngest match wins: scan oldest to youngest, later hits overwrite.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (CNT_W'(i) < count && entries[head + PTR_W'(i)].valid &&
          entries[head + PTR_W'(i)].index == req_index) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[head + PTR_W'(i)].data;
      end
    end
  end

  assign ram_addr = (dmem_re && state == SB_RUN) ? req_index : entries[head].index;

  dmem_ram_array #(.IDX_W(INDEX_W)) u_ram (
    .clock (clock),
    .we    (drain),
    .addr  (ram_addr),
    .wd    (entries[head].data),
    .rd    (ram_rd)
  );

  assign dmem_rd = fwd_hit ? fwd_data : ram_rd;

  // Mode control, stall and flush completion.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    dmem_stall = 1'b0;
    case (state)
      SB_RUN: begin
        dmem_stall = dmem_we && !enq;
        if (flush_req) begin
          if (empty) done_next  = 1'b1;
          else       state_next = SB_FLUSH;
        end
      end
      SB_FLUSH: begin
        dmem_stall = dmem_we || dmem_re;
        // Last entry leaves this edge (or nothing left): done next cycle.
        if (count <= CNT_W'(1)) begin
          state_next = SB_RUN;
          done_next  = 1'b1;
        end
      end
      default: state_next = SB_RUN;
    endcase
  end

  // FIFO pointers, occupancy and mode register.
  always_ff @(posedge clock) begin
    if (reset) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      state  <= SB_RUN;
      done_q <= 1'b0;
      for (int i = 0; i < SB_DEPTH; i++) entries[i].valid <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= done_next;
      if (drain) begin
        entries[head].valid <= 1'b0;
        head <= head + PTR_W'(1);
      end
      // Enqueue after dequeue so a full-buffer swap into the same slot keeps the new entry.
      if (enq) begin
        entries[tail] <= '{valid: 1'b1, index: req_index, data: dmem_wd};
        tail <= tail + PTR_W'(1);
      end
      case ({enq, drain})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign flush_done = done_q;
  assign sb_count   = count;
  assign sb_empty   = empty;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Self-checking bench for dmem_store_buffer: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_dmem_store_buffer;

  localparam int D = 4;

  logic        clock;
  logic        reset;
  logic        dmem_we;
  logic        dmem_re;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wd;
  logic [31:0] dmem_rd;
  logic        dmem_stall;
  logic        flush_req;
  logic        flush_done;
  logic [2:0]  sb_count;
  logic        sb_empty;

  int n_checks = 0;
  int n_errors = 0;

  dmem_store_buffer #(.ADDR_BITS(10), .SB_DEPTH(D)) dut (
    .clock      (clock),
    .reset      (reset),
    .dmem_we    (dmem_we),
    .dmem_re    (dmem_re),
    .dmem_addr  (dmem_addr),
    .dmem_wd    (dmem_wd),
    .dmem_rd    (dmem_rd),
    .dmem_stall (dmem_stall),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .sb_count   (sb_count),
    .sb_empty   (sb_empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: program-ordered queue of pending stores plus a word memory.
  typedef struct {
    int unsigned idx;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mem   [256];
  bit          known [256];
  bit          m_flush = 1'b0;
  bit          m_done  = 1'b0;

  function automatic int unsigned idx_of(input logic [31:0] a);
    return (a >> 2) & 32'hFF;
  endfunction

  function automatic bit m_drain(input bit r);
    return (q.size() > 0) && (m_flush || !r);
  endfunction

  function automatic bit m_stall(input bit w, input bit r);
    if (m_flush) return w || r;
    return w && !(q.size() < D || m_drain(r));
  endfunction

  function automatic bit m_rd_known(input logic [31:0] a);
    for (int i = 0; i < q.size(); i++) if (q[i].idx == idx_of(a)) return 1'b1;
    return known[idx_of(a)];
  endfunction

  function automatic logic [31:0] m_rd(input logic [31:0] a);
    for (int i = q.size() - 1; i >= 0; i--) if (q[i].idx == idx_of(a)) return q[i].data;
    return mem[idx_of(a)];
  endfunction

  task automatic model_step();
    int unsigned n;
    bit          dr;
    ent_t        e;
    n  = q.size();
    dr = m_drain(dmem_re);
    if (dr) begin
      mem[q[0].idx]   = q[0].data;
      known[q[0].idx] = 1'b1;
    end
    if (reset) begin
      q.delete();
      m_flush = 1'b0;
      m_done  = 1'b0;
    end else begin
      m_done = 1'b0;
      if (dr) void'(q.pop_front());
      if (!m_flush) begin
        if (dmem_we && (n < D || dr)) begin
          e.idx  = idx_of(dmem_addr);
          e.data = dmem_wd;
          q.push_back(e);
        end
        if (flush_req) begin
          if (n == 0) m_done  = 1'b1;
          else        m_flush = 1'b1;
        end
      end else if (n <= 1) begin
        m_flush = 1'b0;
        m_done  = 1'b1;
      end
    end
  endtask

  task automatic drive(input bit w, input bit r, input logic [31:0] a,
                       input logic [31:0] d, input bit f = 1'b0, input bit rst = 1'b0);
    dmem_we   = w;
    dmem_re   = r;
    dmem_addr = a;
    dmem_wd   = d;
    flush_req = f;
    reset     = rst;
    @(negedge clock);
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1); tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1); tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    n_checks++; if (sb_count !== 3'd0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", sb_count); end
    n_checks++; if (sb_empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty: got %b expected 1", sb_empty); end
    n_checks++; if (dmem_stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b expected 0", dmem_stall); end
    n_checks++; if (flush_done !== 1'b0) begin n_errors++; $display("FAIL reset_flush_done: got %b expected 0", flush_done); end
    tick();
  endtask

  task automatic test_forward();
    drive(1'b1, 1'b0, 32'h1FC, 32'h4);
    n_checks++; if (dmem_stall !== 1'b0) begin n_errors++; $display("FAIL fwd_store_stall: got %b expected 0", dmem_stall); end
    tick();
    drive(1'b0, 1'b1, 32'h1FC, 32'h0);
    n_checks++; if (dmem_rd !== 32'h4) begin n_errors++; $display("FAIL fwd_rd_buffer: got %h expected 00000004", dmem_rd); end
    n_checks++; if (sb_count !== 3'd1) begin n_errors++; $display("FAIL fwd_count: got %0d expected 1", sb_count); end
    tick();
    idle(1);
    drive(1'b0, 1'b1, 32'h1FC, 32'h0);
    n_checks++; if (sb_empty !== 1'b1) begin n_errors++; $display("FAIL fwd_empty_after_drain: got %b expected 1", sb_empty); end
    n_checks++; if (dmem_rd !== 32'h4) begin n_errors++; $display("FAIL fwd_rd_ram: got %h expected 00000004", dmem_rd); end
    tick();
  endtask

  task automatic test_full_stall();
    logic [31:0] a [4] = '{32'h1FC, 32'h1F8, 32'h1F4, 32'h1F0};
    logic [31:0] d [4] = '{32'h4, 32'hC, 32'h3, 32'h58};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, a[i], d[i]);
      n_checks++; if (dmem_stall !== 1'b0) begin n_errors++; $display("FAIL full_fill_stall_%0d: got %b expected 0", i, dmem_stall); end
      tick();
    end
    drive(1'b1, 1'b1, 32'h1EC, 32'h77);
    n_checks++; if (sb_count !== 3'd4) begin n_errors++; $display("FAIL full_count: got %0d expected 4", sb_count); end
    n_checks++; if (dmem_stall !== 1'b1) begin n_errors++; $display("FAIL full_fifth_stall: got %b expected 1", dmem_stall); end
    tick();
    drive(1'b1, 1'b0, 32'h1EC, 32'h77);
    n_checks++; if (dmem_stall !== 1'b0) begin n_errors++; $display("FAIL full_swap_accept: got %b expected 0", dmem_stall); end
    tick();
    drive(1'b0, 1'b1, 32'h1EC, 32'h0);
    n_checks++; if (sb_count !== 3'd4) begin n_errors++; $display("FAIL full_swap_count: got %0d expected 4", sb_count); end
    n_checks++; if (dmem_rd !== 32'h77) begin n_errors++; $display("FAIL full_swap_fwd: got %h expected 00000077", dmem_rd); end
    tick();
    idle(5);
    drive(1'b0, 1'b1, 32'h1F0, 32'h0);
    n_checks++; if (sb_empty !== 1'b1) begin n_errors++; $display("FAIL full_drained: got %b expected 1", sb_empty); end
    n_checks++; if (dmem_rd !== 32'h58) begin n_errors++; $display("FAIL full_ram_1f0: got %h expected 00000058", dmem_rd); end
    tick();
  endtask

  task automatic test_youngest();
    drive(1'b1, 1'b1, 32'h1E8, 32'h58); tick();
    drive(1'b1, 1'b1, 32'h1E8, 32'h2);  tick();
    drive(1'b0, 1'b1, 32'h1E8, 32'h0);
    n_checks++; if (dmem_rd !== 32'h2) begin n_errors++; $display("FAIL young_fwd: got %h expected 00000002", dmem_rd); end
    n_checks++; if (sb_count !== 3'd2) begin n_errors++; $display("FAIL young_count: got %0d expected 2", sb_count); end
    tick();
    idle(3);
    drive(1'b0, 1'b1, 32'h1E8, 32'h0);
    n_checks++; if (dmem_rd !== 32'h2) begin n_errors++; $display("FAIL young_ram: got %h expected 00000002", dmem_rd); end
    tick();
  endtask

  task automatic test_flush();
    logic [31:0] d [3];
    for (int i = 0; i < 3; i++) begin
      d[i] = $urandom;
      drive(1'b1, 1'b1, 32'h040 + 32'(4 * i), d[i]); tick();
    end
    drive(1'b0, 1'b1, 32'h048, 32'h0, 1'b1);
    n_checks++; if (dmem_stall !== 1'b0) begin n_errors++; $display("FAIL flush_req_stall: got %b expected 0", dmem_stall); end
    n_checks++; if (dmem_rd !== d[2]) begin n_errors++; $display("FAIL flush_req_rd: got %h expected %h", dmem_rd, d[2]); end
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 32'h048, 32'h0);
      n_checks++; if (dmem_stall !== 1'b1) begin n_errors++; $display("FAIL flush_stall_%0d: got %b expected 1", k, dmem_stall); end
      n_checks++; if (flush_done !== 1'b0) begin n_errors++; $display("FAIL flush_early_done_%0d: got %b expected 0", k, flush_done); end
      n_checks++; if (sb_count !== 3'(3 - k)) begin n_errors++; $display("FAIL flush_count_%0d: got %0d expected %0d", k, sb_count, 3 - k); end
      tick();
    end
    drive(1'b0, 1'b1, 32'h048, 32'h0);
    n_checks++; if (flush_done !== 1'b1) begin n_errors++; $display("FAIL flush_done_pulse: got %b expected 1", flush_done); end
    n_checks++; if (sb_count !== 3'd0) begin n_errors++; $display("FAIL flush_done_count: got %0d expected 0", sb_count); end
    n_checks++; if (dmem_stall !== 1'b0) begin n_errors++; $display("FAIL flush_after_stall: got %b expected 0", dmem_stall); end
    n_checks++; if (dmem_rd !== d[2]) begin n_errors++; $display("FAIL flush_after_rd: got %h expected %h", dmem_rd, d[2]); end
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    n_checks++; if (flush_done !== 1'b0) begin n_errors++; $display("FAIL flush_done_width: got %b expected 0", flush_done); end
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    n_checks++; if (flush_done !== 1'b1) begin n_errors++; $display("FAIL flush_empty_done: got %b expected 1", flush_done); end
    tick();
  endtask

  task automatic test_reset_pending();
    logic [31:0] a;
    a = $urandom;
    drive(1'b1, 1'b0, 32'h080, a); tick();
    idle(2);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'h080 + 32'(4 * i), $urandom); tick();
    end
    drive(1'b0, 1'b1, 32'h080, 32'h0, 1'b0, 1'b1);
    n_checks++; if (sb_count !== 3'd3) begin n_errors++; $display("FAIL rstp_pre_count: got %0d expected 3", sb_count); end
    tick();
    drive(1'b0, 1'b1, 32'h080, 32'h0);
    n_checks++; if (sb_count !== 3'd0) begin n_errors++; $display("FAIL rstp_count: got %0d expected 0", sb_count); end
    n_checks++; if (dmem_rd !== a) begin n_errors++; $display("FAIL rstp_ram_rd: got %h expected %h", dmem_rd, a); end
    tick();
  endtask

  task automatic test_alias();
    logic [31:0] v;
    v = $urandom;
    drive(1'b1, 1'b1, 32'h5FC, v); tick();
    drive(1'b0, 1'b1, 32'h1FC, 32'h0);
    n_checks++; if (dmem_rd !== v) begin n_errors++; $display("FAIL alias_fwd: got %h expected %h", dmem_rd, v); end
    tick();
    idle(2);
  endtask

  task automatic test_random();
    bit          w, r, f, rst;
    logic [31:0] a;
    for (int c = 0; c < 600; c++) begin
      w   = ($urandom_range(0, 99) < 55);
      r   = ($urandom_range(0, 99) < 45);
      f   = ($urandom_range(0, 99) < 4);
      rst = ($urandom_range(0, 199) == 0);
      a   = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 7)) << 2) | ($urandom & 32'h3);
      drive(w, r, a, $urandom, f, rst);
      n_checks++; if (dmem_stall !== m_stall(w, r)) begin n_errors++; $display("FAIL rand_stall c%0d: got %b expected %b", c, dmem_stall, m_stall(w, r)); end
      n_checks++; if (sb_count !== 3'(q.size())) begin n_errors++; $display("FAIL rand_count c%0d: got %0d expected %0d", c, sb_count, q.size()); end
      n_checks++; if (sb_empty !== (q.size() == 0)) begin n_errors++; $display("FAIL rand_empty c%0d: got %b expected %b", c, sb_empty, q.size() == 0); end
      n_checks++; if (flush_done !== m_done) begin n_errors++; $display("FAIL rand_flush_done c%0d: got %b expected %b", c, flush_done, m_done); end
      if (r && !m_flush && m_rd_known(a)) begin
        n_checks++; if (dmem_rd !== m_rd(a)) begin n_errors++; $display("FAIL rand_rd c%0d addr %h: got %h expected %h", c, a, dmem_rd, m_rd(a)); end
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]   = '0;
      known[i] = 1'b0;
    end
    test_reset();
    test_forward();
    test_full_stall();
    test_youngest();
    test_flush();
    test_reset_pending();
    test_alias();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
